// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 sensor emulator: FSM states, protocol
// timing in microseconds and the checksum rule.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    RESP_DELAY,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  localparam int unsigned RESP_DELAY_US = 30;
  localparam int unsigned RESP_LOW_US   = 80;
  localparam int unsigned RESP_HIGH_US  = 80;
  localparam int unsigned BIT_LOW_US    = 50;
  localparam int unsigned BIT0_HIGH_US  = 26;
  localparam int unsigned BIT1_HIGH_US  = 70;
  localparam int unsigned END_LOW_US    = 50;
  localparam int unsigned FRAME_BITS    = 40;

  function automatic logic [7:0] frame_checksum(input logic [31:0] data, input logic corrupt);
    return (data[31:24] + data[23:16] + data[15:8] + data[7:0]) ^ {7'b0, corrupt};
  endfunction

endpackage

// File: rtl/microsecond_tick.sv
// Free-running prescaler producing a one-cycle pulse every microsecond.
module microsecond_tick #(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  output logic us_tick
);

  localparam int unsigned DIV_RAW = CLK_FREQ_HZ / 1000000;
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

  logic [31:0] cnt_q, cnt_d;

  assign us_tick = (cnt_q == 32'(DIV - 1));

  always_comb begin
    cnt_d = us_tick ? '0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_emulator.sv
// DHT11 sensor emulator: detects the host start pulse on the open-drain wire
// and answers with the 80/80 us preamble, 40 data bits and the end pulse.
module dht11_emulator
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned START_MIN_US = 18000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_dec,
  input  logic [7:0] temperature_int,
  input  logic [7:0] temperature_dec,
  input  logic       corrupt_checksum,
  inout  wire        transmission_line,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

  logic        sync1_q, sync2_q;
  logic        us_tick;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] snap_q, snap_d;
  logic        corrupt_q, corrupt_d;
  logic        done_q, done_d;
  logic        drive_low;
  logic [15:0] dur;
  logic        expire;
  logic [39:0] frame_bits;
  logic        cur_bit;

  microsecond_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .us_tick (us_tick)
  );

  assign transmission_line = drive_low ? 1'b0 : 1'bz;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

  assign frame_bits = {snap_q, frame_checksum(snap_q, corrupt_q)};
  assign cur_bit    = frame_bits[LAST_BIT - bit_q];

  always_comb begin
    dur = 16'd1;
    case (state_q)
      RESP_DELAY: dur = 16'(RESP_DELAY_US);
      RESP_LOW:   dur = 16'(RESP_LOW_US);
      RESP_HIGH:  dur = 16'(RESP_HIGH_US);
      BIT_LOW:    dur = 16'(BIT_LOW_US);
      BIT_HIGH:   dur = cur_bit ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
      END_LOW:    dur = 16'(END_LOW_US);
      default:    dur = 16'd1;
    endcase
    expire = us_tick && (cnt_q == dur - 16'd1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    snap_d    = snap_q;
    corrupt_d = corrupt_q;
    done_d    = 1'b0;
    drive_low = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !sync2_q) begin
          state_d = START_LOW;
          cnt_d   = '0;
        end
      end
      START_LOW: begin
        if (sync2_q) begin
          cnt_d = '0;
          if ({16'd0, cnt_q} >= START_MIN_US) begin
            state_d   = RESP_DELAY;
            snap_d    = {humidity_int, humidity_dec, temperature_int, temperature_dec};
            corrupt_d = corrupt_checksum;
          end else begin
            state_d = IDLE;
          end
        end else if (us_tick && cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        // Timed states share one counter; the line is ignored until the frame ends.
        drive_low = (state_q == RESP_LOW) || (state_q == BIT_LOW) || (state_q == END_LOW);
        if (expire) cnt_d = '0;
        else if (us_tick) cnt_d = cnt_q + 16'd1;
        if (expire) begin
          case (state_q)
            RESP_DELAY: state_d = RESP_LOW;
            RESP_LOW:   state_d = RESP_HIGH;
            RESP_HIGH: begin
              state_d = BIT_LOW;
              bit_d   = '0;
            end
            BIT_LOW:    state_d = BIT_HIGH;
            BIT_HIGH: begin
              if (bit_q == LAST_BIT) begin
                state_d = END_LOW;
              end else begin
                state_d = BIT_LOW;
                bit_d   = bit_q + 6'd1;
              end
            end
            END_LOW: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            default:    state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      snap_q    <= '0;
      corrupt_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= transmission_line;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      snap_q    <= snap_d;
      corrupt_q <= corrupt_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_dht11_emulator.sv
// Self-checking bench for dht11_emulator: host-side start pulses, frame
// decoding from pulse widths and comparison against a checksum model.
module tb_dht11_emulator;

  // Start threshold scaled down ten-fold so the whole run stays short.
  localparam int START_MIN = 1800;
  localparam int VALID_LOW = 1810;
  localparam int SHORT_LOW = 1000;
  localparam int RUN_BOUND = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] humidity_int = '0, humidity_dec = '0;
  logic [7:0] temperature_int = '0, temperature_dec = '0;
  logic       corrupt_checksum = 1'b0;
  logic       host_low = 1'b0;
  logic       busy, frame_done;
  wire        transmission_line;

  int tests_run = 0;
  int tests_failed = 0;
  int fd_count = 0;

  pullup (transmission_line);
  assign transmission_line = host_low ? 1'b0 : 1'bz;

  dht11_emulator #(.CLK_FREQ_HZ(1000000), .START_MIN_US(START_MIN)) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .humidity_int      (humidity_int),
    .humidity_dec      (humidity_dec),
    .temperature_int   (temperature_int),
    .temperature_dec   (temperature_dec),
    .corrupt_checksum  (corrupt_checksum),
    .transmission_line (transmission_line),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_done === 1'b1) fd_count++;

  function automatic logic [39:0] model_frame(input int a, b, c, d, input int cor);
    int cs;
    cs = ((a + b + c + d) % 256) ^ cor;
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(cs)};
  endfunction

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (transmission_line === lvl && len < RUN_BOUND) begin
      @(negedge clock);
      len++;
    end
  endtask

  task automatic host_start(input int low_us);
    @(negedge clock);
    host_low = 1'b1;
    repeat (low_us) @(negedge clock);
    host_low = 1'b0;
    #1;
  endtask

  task automatic do_frame(input logic [7:0] a, b, c, d, input logic cor, input int change_bit,
                          output logic [39:0] bits, output int plo, output int phi,
                          output int fdd, output bit tmo);
    int fd0, lo, hi, n;
    humidity_int = a; humidity_dec = b; temperature_int = c; temperature_dec = d;
    corrupt_checksum = cor;
    tmo = 1'b0;
    bits = '0;
    fd0 = fd_count;
    host_start(VALID_LOW);
    run_len(1'b1, n);   if (n >= RUN_BOUND) tmo = 1'b1;
    run_len(1'b0, plo); if (plo >= RUN_BOUND) tmo = 1'b1;
    run_len(1'b1, phi); if (phi >= RUN_BOUND) tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == change_bit) begin
        humidity_int = '0; humidity_dec = '0; temperature_int = '0; temperature_dec = '0;
        corrupt_checksum = ~cor;
      end
      run_len(1'b0, lo); if (lo >= RUN_BOUND) tmo = 1'b1;
      run_len(1'b1, hi); if (hi >= RUN_BOUND) tmo = 1'b1;
      bits[39 - i] = (hi > 48);
    end
    run_len(1'b0, n); if (n >= RUN_BOUND) tmo = 1'b1;
    repeat (3) @(negedge clock);
    fdd = fd_count - fd0;
  endtask

  task automatic check_frame(input string name, input logic [39:0] exp, input logic [39:0] got,
                             input int plo, input int phi, input int fdd, input bit tmo);
    tests_run++;
    if (tmo !== 1'b0) begin tests_failed++; $display("FAIL %s_timeout: a pulse exceeded %0d cycles", name, RUN_BOUND); end
    tests_run++;
    if (plo !== 80) begin tests_failed++; $display("FAIL %s_resp_low: got %0d us, want 80", name, plo); end
    tests_run++;
    if (phi !== 80) begin tests_failed++; $display("FAIL %s_resp_high: got %0d us, want 80", name, phi); end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (got[39 - 8*k -: 8] !== exp[39 - 8*k -: 8]) begin
        tests_failed++;
        $display("FAIL %s_byte%0d: got %02h, want %02h", name, k, got[39 - 8*k -: 8], exp[39 - 8*k -: 8]);
      end
    end
    tests_run++;
    if (fdd !== 1) begin tests_failed++; $display("FAIL %s_frame_done: got %0d pulses, want 1", name, fdd); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL %s_busy_after: got %b, want 0", name, busy); end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (transmission_line !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: line=%b busy=%b done=%b, want 1 0 0", transmission_line, busy, frame_done);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_basic_frame();
    logic [39:0] got; int plo, phi, fdd; bit tmo;
    do_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, -1, got, plo, phi, fdd, tmo);
    check_frame("basic", 40'h37_00_19_05_55, got, plo, phi, fdd, tmo);
  endtask

  task automatic test_checksum_wrap();
    logic [39:0] got; int plo, phi, fdd; bit tmo;
    do_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0, -1, got, plo, phi, fdd, tmo);
    check_frame("wrap", 40'hFF_FF_01_02_01, got, plo, phi, fdd, tmo);
  endtask

  task automatic test_corrupt();
    logic [39:0] got; int plo, phi, fdd; bit tmo;
    do_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b1, -1, got, plo, phi, fdd, tmo);
    check_frame("corrupt", 40'h37_00_19_05_54, got, plo, phi, fdd, tmo);
  endtask

  task automatic test_snapshot_hold();
    logic [39:0] got; int plo, phi, fdd; bit tmo;
    do_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 5, got, plo, phi, fdd, tmo);
    check_frame("snapshot", 40'h37_00_19_05_55, got, plo, phi, fdd, tmo);
    corrupt_checksum = 1'b0;
  endtask

  task automatic no_response(input string name, input int low_us);
    int busy_cnt, drv_cnt, fd0;
    busy_cnt = 0; drv_cnt = 0; fd0 = fd_count;
    @(negedge clock);
    host_low = 1'b1;
    for (int i = 0; i < low_us + 300; i++) begin
      @(negedge clock);
      if (i == low_us) host_low = 1'b0;
      if ((!enable || i >= low_us + 5) && busy !== 1'b0) busy_cnt++;
      if (i > low_us && transmission_line !== 1'b1) drv_cnt++;
    end
    tests_run++;
    if (busy_cnt !== 0) begin tests_failed++; $display("FAIL %s_busy: busy seen %0d cycles, want 0", name, busy_cnt); end
    tests_run++;
    if (drv_cnt !== 0) begin tests_failed++; $display("FAIL %s_line: driven low %0d cycles, want 0", name, drv_cnt); end
    tests_run++;
    if (fd_count - fd0 !== 0) begin tests_failed++; $display("FAIL %s_frame_done: got %0d pulses, want 0", name, fd_count - fd0); end
  endtask

  task automatic test_short_start();
    no_response("short", SHORT_LOW);
  endtask

  task automatic test_enable_low();
    enable = 1'b0;
    no_response("enable_low", VALID_LOW);
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] got; int plo, phi, fdd, n; bit tmo; logic line_before;
    humidity_int = 8'h37; humidity_dec = 8'h00; temperature_int = 8'h19; temperature_dec = 8'h05;
    corrupt_checksum = 1'b0;
    host_start(VALID_LOW);
    run_len(1'b1, n); run_len(1'b0, n); run_len(1'b1, n);
    for (int i = 0; i < 20; i++) begin
      run_len(1'b0, n); run_len(1'b1, n);
    end
    repeat (10) @(negedge clock);
    line_before = transmission_line;
    tests_run++;
    if (line_before !== 1'b0) begin tests_failed++; $display("FAIL midreset_in_bit20: line=%b, want 0", line_before); end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (transmission_line !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async: line=%b busy=%b, want 1 0", transmission_line, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    do_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, -1, got, plo, phi, fdd, tmo);
    check_frame("after_reset", 40'h37_00_19_05_55, got, plo, phi, fdd, tmo);
  endtask

  task automatic test_random();
    logic [39:0] got, exp; int plo, phi, fdd; bit tmo; int a, b, c, d, cor;
    for (int r = 0; r < 2; r++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      c = $urandom_range(0, 255); d = $urandom_range(0, 255);
      cor = $urandom_range(0, 1);
      exp = model_frame(a, b, c, d, cor);
      do_frame(8'(a), 8'(b), 8'(c), 8'(d), cor[0], -1, got, plo, phi, fdd, tmo);
      check_frame("random", exp, got, plo, phi, fdd, tmo);
    end
    corrupt_checksum = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_short_start();
    test_checksum_wrap();
    test_corrupt();
    test_reset_mid_frame();
    test_snapshot_hold();
    test_enable_low();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
